// File: rtl/dmem_resp_pkg.sv
// Shared widths, default depth and the address/mask check helper for dmem_resp.
// The check helper is only used when DMEM_ADDR_CHK_EN is defined.
package dmem_resp_pkg;

  localparam int unsigned MemWidth     = 32;
  localparam int unsigned MemUnit      = MemWidth / 8;
  localparam int unsigned MemAddrWidth = 32;
  localparam int unsigned DMEM_DEPTH   = 1024;

  // Wide enough for the largest legal LATENCY (15).
  localparam int unsigned CntWidth = 4;

  typedef logic [MemWidth-1:0]     mem_bus_t;
  typedef logic [MemAddrWidth-1:0] mem_addr_bus_t;

  // Only writes are alignment-checked; half-word and word masks need natural alignment.
  function automatic logic misaligned(input logic we, input logic [MemUnit-1:0] wem,
                                      input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (we) begin
      if (wem == 4'b0011) bad = lsb[0];
      if (wem == 4'b1111) bad = |lsb;
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Contents are never reset; the read register holds its value until the next read.
module dmem_ram
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [MemUnit-1:0] be_i,
  input  logic [AW-1:0]      addr_i,
  input  mem_bus_t           wdata_i,
  output mem_bus_t           rdata_o
);

  mem_bus_t mem_q [DEPTH];
  mem_bus_t rdata_q;

  always_ff @(posedge clk) begin
    if (req_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(MemUnit); i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one request, stalls the pipeline for LATENCY cycles, then
// pulses rsp_valid. Define DMEM_ADDR_CHK_EN to enable range/alignment errors on err_o.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = DMEM_DEPTH,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_i,
  input  logic                    mem_we_i,
  input  logic [MemUnit-1:0]      mem_wem_i,
  input  logic [MemWidth-1:0]     mem_din,
  input  logic [MemAddrWidth-1:0] mem_addr_i,
  output logic [MemWidth-1:0]     mem_dout,
  output logic                    rsp_valid,
  output logic                    stall_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [CntWidth-1:0] CntInit = CntWidth'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                read_q, read_d;
  logic                err_q, err_d;
  mem_bus_t            dout_q, dout_d;

  logic                accept;
  logic                req_err;
  logic                ram_req;
  logic [AW-1:0]       word_idx;
  mem_bus_t            ram_rdata;
  mem_bus_t            rd_word;

  assign accept   = (state_q == StIdle) & cs_i;
  assign word_idx = mem_addr_i[AW+1:2];

`ifdef DMEM_ADDR_CHK_EN
  localparam logic [MemAddrWidth:0] AddrLimit = (MemAddrWidth + 1)'(DEPTH) << 2;

  assign req_err = ({1'b0, mem_addr_i} >= AddrLimit) |
                   misaligned(mem_we_i, mem_wem_i, mem_addr_i[1:0]);
`else
  logic unused_addr;

  // Upper bits are dropped so the index wraps modulo DEPTH.
  assign unused_addr = ^{mem_addr_i[1:0], mem_addr_i[MemAddrWidth-1:AW+2]};
  assign req_err     = 1'b0;
`endif

  // The write commits at the acceptance edge; erroneous requests never touch the RAM.
  assign ram_req = accept & ~req_err & ~rst;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .req_i   (ram_req),
    .we_i    (mem_we_i),
    .be_i    (mem_wem_i),
    .addr_i  (word_idx),
    .wdata_i (mem_din),
    .rdata_o (ram_rdata)
  );

  assign rd_word = err_q ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    err_d   = err_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (cs_i) begin
          read_d  = ~mem_we_i;
          err_d   = req_err;
          cnt_d   = CntInit;
          state_d = (LATENCY > 1) ? StBusy : StResp;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntWidth'(1)) state_d = StResp;
      end
      StResp: begin
        if (read_q) dout_d = rd_word;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid = (state_q == StResp);
  assign mem_dout  = (rsp_valid & read_q) ? rd_word : dout_q;
  assign stall_o   = ~rst & (accept | (state_q == StBusy));

`ifdef DMEM_ADDR_CHK_EN
  assign err_o = rsp_valid & err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: LATENCY=1 and LATENCY=4 instances checked every cycle against a
// transaction-level model, plus directed literal expectations.
module tb_dmem_resp;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs   [2];
  logic        we   [2];
  logic [3:0]  wem  [2];
  logic [31:0] din  [2];
  logic [31:0] addr [2];
  logic [31:0] dout [2];
  logic        rv   [2];
  logic        st   [2];
  logic        er   [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk   = 1'b0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(Depth), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .cs_i(cs[0]), .mem_we_i(we[0]), .mem_wem_i(wem[0]),
    .mem_din(din[0]), .mem_addr_i(addr[0]), .mem_dout(dout[0]), .rsp_valid(rv[0]),
    .stall_o(st[0]), .err_o(er[0])
  );

  dmem_resp #(.DEPTH(Depth), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .cs_i(cs[1]), .mem_we_i(we[1]), .mem_wem_i(wem[1]),
    .mem_din(din[1]), .mem_addr_i(addr[1]), .mem_dout(dout[1]), .rsp_valid(rv[1]),
    .stall_o(st[1]), .err_o(er[1])
  );

  // Transaction model: one outstanding request per instance, response due at a cycle number.
  logic [31:0] mmem  [2][Depth];
  bit          pend  [2];
  int          rcyc  [2];
  bit          rread [2];
  bit          rerr  [2];
  logic [31:0] rdata [2];
  logic [31:0] hold  [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit addr_err(input logic w, input logic [3:0] m, input logic [31:0] a);
    bit bad;
    bad = 1'b0;
`ifdef DMEM_ADDR_CHK_EN
    if (a >= Depth * 4) bad = 1'b1;
    if (w && m == 4'b0011 && a[0]) bad = 1'b1;
    if (w && m == 4'b1111 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    return bad;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, i, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int idx;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pend[i] = 1'b0;
        hold[i] = '0;
      end else if (pend[i]) begin
        if (cyc == rcyc[i] + 1) begin
          pend[i] = 1'b0;
          if (rread[i]) hold[i] = rdata[i];
        end
      end else if (cs[i]) begin
        idx      = int'((addr[i] >> 2) % Depth);
        pend[i]  = 1'b1;
        rcyc[i]  = cyc + lat(i) - 1;
        rread[i] = !we[i];
        rerr[i]  = addr_err(we[i], wem[i], addr[i]);
        if (we[i]) begin
          if (!rerr[i]) begin
            for (int b = 0; b < 4; b++) begin
              if (wem[i][b]) mmem[i][idx][8*b +: 8] = din[i][8*b +: 8];
            end
          end
        end else begin
          rdata[i] = rerr[i] ? 32'h0 : mmem[i][idx];
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        e_rv, e_st, e_er;
    logic [31:0] e_do;
    if (chk) begin
      for (int i = 0; i < 2; i++) begin
        e_rv = pend[i] && (cyc == rcyc[i]);
        e_st = !rst && (pend[i] ? (cyc < rcyc[i]) : cs[i]);
        e_do = (e_rv && rread[i]) ? rdata[i] : hold[i];
        e_er = e_rv && rerr[i];
        check("rsp_valid", i, 32'(rv[i]), 32'(e_rv));
        check("stall_o",   i, 32'(st[i]), 32'(e_st));
        check("err_o",     i, 32'(er[i]), 32'(e_er));
        check("mem_dout",  i, dout[i], e_do);
      end
    end
  end

  // Presents a request in an IDLE cycle; it is accepted at the following edge.
  task automatic req(input int i, input logic w, input logic [3:0] m, input logic [31:0] d,
                     input logic [31:0] a);
    @(posedge clk);
    #2;
    cs[i] = 1'b1; we[i] = w; wem[i] = m; din[i] = d; addr[i] = a;
    #1;
    check("accept_stall", i, 32'(st[i]), 32'd1);
    @(posedge clk);
    #2;
    cs[i] = 1'b0;
  endtask

  // Counts cycles after acceptance until rsp_valid; n = -1 if it never arrives.
  task automatic wait_rsp(input int i, output int n, output logic [31:0] d, output logic e);
    n = -1;
    d = '0;
    e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rv[i]) begin
        n = k;
        d = dout[i];
        e = er[i];
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [31:0] d;
    logic        e;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cs[i] = 1'b1; we[i] = 1'b0; wem[i] = 4'h0; din[i] = '0; addr[i] = '0;
    end
    @(posedge clk);
    #2;
    chk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_stall", i, 32'(st[i]), 32'd0);
      check("rst_rsp",   i, 32'(rv[i]), 32'd0);
      check("rst_dout",  i, dout[i], 32'h0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("idle_cs_stall", 0, 32'(st[0]), 32'd1);
    check("idle_cs_stall", 1, 32'(st[1]), 32'd1);
    cs[0] = 1'b0;
    cs[1] = 1'b0;

    // LATENCY=1 write then read-back
    req(0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h10);
    wait_rsp(0, n, d, e);
    check("wr_lat1", 0, 32'(n), 32'd1);
    req(0, 1'b0, 4'h0, 32'h0, 32'h10);
    wait_rsp(0, n, d, e);
    check("rd_lat1", 0, 32'(n), 32'd1);
    check("rd_data", 0, d, 32'hDEADBEEF);
    check("resp_stall", 0, 32'(st[0]), 32'd0);

    // Byte-lane mask
    req(0, 1'b1, 4'hF, 32'h11223344, 32'h20);
    wait_rsp(0, n, d, e);
    req(0, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h20);
    wait_rsp(0, n, d, e);
    req(0, 1'b0, 4'h0, 32'h0, 32'h20);
    wait_rsp(0, n, d, e);
    check("mask_rd", 0, d, 32'h11BB33DD);

    // Empty mask still responds and leaves RAM unchanged
    req(0, 1'b1, 4'h0, 32'h0, 32'h20);
    wait_rsp(0, n, d, e);
    check("wem0_rsp", 0, 32'(n), 32'd1);
    req(0, 1'b0, 4'h0, 32'h0, 32'h20);
    wait_rsp(0, n, d, e);
    check("wem0_rd", 0, d, 32'h11BB33DD);

    // LATENCY=4 with inputs changing during BUSY
    req(1, 1'b1, 4'hF, 32'h12345678, 32'h40);
    wait_rsp(1, n, d, e);
    check("wr_lat4", 1, 32'(n), 32'd4);
    req(1, 1'b0, 4'h0, 32'h0, 32'h40);
    addr[1] = 32'h10;
    din[1]  = 32'hFFFFFFFF;
    we[1]   = 1'b1;
    wait_rsp(1, n, d, e);
    check("rd_lat4", 1, 32'(n), 32'd4);
    check("rd_lat4_data", 1, d, 32'h12345678);

    // Reset while BUSY aborts the response but keeps the committed write
    req(1, 1'b1, 4'hF, 32'h5, 32'h80);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv[1]) n++;
    end
    check("abort_no_rsp", 1, 32'(n), 32'd0);
    req(1, 1'b0, 4'h0, 32'h0, 32'h80);
    wait_rsp(1, n, d, e);
    check("abort_rd", 1, d, 32'h5);

    // Out-of-range address
    req(0, 1'b1, 4'hF, 32'h01020304, 32'h0);
    wait_rsp(0, n, d, e);
    req(0, 1'b1, 4'hF, 32'hCAFEF00D, 32'h1000);
    wait_rsp(0, n, d, e);
`ifdef DMEM_ADDR_CHK_EN
    check("oob_wr_err", 0, 32'(e), 32'd1);
`else
    check("oob_wr_err", 0, 32'(e), 32'd0);
`endif
    req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_rsp(0, n, d, e);
`ifdef DMEM_ADDR_CHK_EN
    check("oob_word0", 0, d, 32'h01020304);
`else
    check("oob_word0", 0, d, 32'hCAFEF00D);
`endif
    req(0, 1'b0, 4'h0, 32'h0, 32'h1000);
    wait_rsp(0, n, d, e);
`ifdef DMEM_ADDR_CHK_EN
    check("oob_rd", 0, d, 32'h0);
    check("oob_rd_err", 0, 32'(e), 32'd1);
`else
    check("oob_rd", 0, d, 32'hCAFEF00D);
    check("oob_rd_err", 0, 32'(e), 32'd0);
`endif
    req(0, 1'b1, 4'hF, 32'h77, 32'h22);
    wait_rsp(0, n, d, e);
`ifdef DMEM_ADDR_CHK_EN
    check("misalign_err", 0, 32'(e), 32'd1);
`else
    check("misalign_err", 0, 32'(e), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
